fixed_linear_weight_source: RTL
===============================

FIXED_LINEAR_WEIGHT_SOURCE -- requirements
Module: fixed_linear_weight_source

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WEIGHT_WIDTH, 16, bits per weight element.
- IN_SIZE, 4, elements per input beat of the consuming linear layer.
- PARALLELISM, 2, output features computed per chunk.
- IN_DEPTH, 3, input beats per output chunk.
- OUT_DEPTH, 2, output chunks per full weight matrix.
- PASS_WIDTH, 8, width of num_passes.
- WEIGHT_SIZE, IN_SIZE*PARALLELISM, elements per weight beat (derived).
- NUM_BEATS, OUT_DEPTH*IN_DEPTH, stored beats (derived).
- ADDR_WIDTH, max(1,$clog2(NUM_BEATS)), memory address width (derived).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, reset: asynchronous, active-low.
- wr_en, in, 1, memory write strobe.
- wr_addr, in, ADDR_WIDTH, beat address to write.
- wr_data, in, WEIGHT_WIDTH x [WEIGHT_SIZE], one full weight beat.
- start, in, 1, begin streaming, sampled while idle.
- num_passes, in, PASS_WIDTH, number of full-matrix passes, sampled with start.
- busy, out, 1, high from accepted start until done.
- done, out, 1, one-cycle pulse at end of command.
- weight, out, WEIGHT_WIDTH x [WEIGHT_SIZE], weight beat; element IN_SIZE*i+k feeds feature lane i, input element k.
- weight_valid, out, 1, beat valid.
- weight_ready, in, 1, consumer ready.

Function
REQ-003 Internal storage SHALL hold NUM_BEATS beats with a synchronous write and a synchronous 1-cycle-latency read.
REQ-004 A write SHALL take effect when wr_en=1 and busy=0. A write while busy=1 SHALL be ignored.
REQ-005 A wr_addr >= NUM_BEATS SHALL be ignored.
REQ-006 The FSM SHALL have two states, IDLE and STREAM.
- IDLE->STREAM on start=1 with num_passes>0; num_passes is latched.
- start=1 with num_passes=0 SHALL stay in IDLE, emit no beats, and pulse done on the next cycle.
- start while in STREAM SHALL be ignored.
REQ-007 Beat order in STREAM SHALL be address 0,1,...,NUM_BEATS-1, wrapping to 0 after each pass.
- Address o*IN_DEPTH+d carries output chunk o, input beat d.
- Exactly num_passes*NUM_BEATS beats SHALL be emitted.
REQ-008 The output SHALL follow the valid/ready rule: a beat transfers on a clk edge with weight_valid=1 and weight_ready=1. While weight_valid=1 and weight_ready=0, weight SHALL hold stable.
REQ-009 weight_valid SHALL first assert on the 2nd rising edge after the edge that accepts start.
REQ-010 Throughput SHALL be one beat per cycle while weight_ready=1, with no bubbles across pass wraps.
- Prefetch plus a 2-entry output buffer SHALL absorb read latency.
- weight_ready SHALL NOT combinationally reach the memory address.
REQ-011 No read SHALL be issued beyond the final beat; the buffer SHALL never overflow or duplicate a beat under any weight_ready pattern.
REQ-012 On the edge transferring the final beat, the block SHALL return to IDLE and deassert busy. done SHALL be high for exactly the following cycle.
REQ-013 A new start SHALL be accepted in the cycle done is high.

Reset
REQ-014 While rst=0, outputs SHALL be busy=0, done=0, weight_valid=0, weight all zeros.
REQ-015 rst=0 SHALL clear the FSM (IDLE), counters and buffer; mid-stream beats are discarded with no done pulse.
REQ-016 Memory contents SHALL NOT be reset and SHALL survive reset.

Verification
REQ-017 Load: write beats 0..5 with element j of beat a = 16*a+j; start, num_passes=1, weight_ready=1.
-> 6 beats in address order, valid at edge 2, contiguous, then done pulse, busy=0.
REQ-018 Backpressure: num_passes=3, weight_ready randomized at 50%.
-> 18 beats, sequence 0..5 three times, no drops or duplicates, stable data while stalled.
REQ-019 Zero passes: start with num_passes=0.
-> no weight_valid, done pulses next cycle, busy stays 0.
REQ-020 Write while busy to address 2 with all 0xFFFF, then a second pass.
-> beat 2 unchanged.
REQ-021 Reset mid-stream after 3 beats.
-> outputs zero asynchronously; after release, start num_passes=1 streams original beats 0..5 intact.
REQ-022 Start in the done cycle.
-> new command accepted, weight_valid two edges later.

Source files
------------

// File: rtl/fixed_linear_weight_source.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fixed_linear_weight_source
//  Description : Holds a full weight matrix for a linear layer and streams it
//                out beat by beat, one or more passes per command, over a
//                valid/ready interface. Reads are prefetched into a two-entry
//                output buffer so the stream runs at one beat per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_linear_weight_source #(
    parameter int WEIGHT_WIDTH = 16,
    parameter int IN_SIZE      = 4,
    parameter int PARALLELISM  = 2,
    parameter int IN_DEPTH     = 3,
    parameter int OUT_DEPTH    = 2,
    parameter int PASS_WIDTH   = 8,
    parameter int WEIGHT_SIZE  = IN_SIZE * PARALLELISM,
    parameter int NUM_BEATS    = OUT_DEPTH * IN_DEPTH,
    parameter int ADDR_WIDTH   = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,            // asynchronous, active-low
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WEIGHT_WIDTH-1:0] wr_data [WEIGHT_SIZE],
    input  logic                    start,
    input  logic [PASS_WIDTH-1:0]   num_passes,
    output logic                    busy,
    output logic                    done,
    output logic [WEIGHT_WIDTH-1:0] weight [WEIGHT_SIZE],
    output logic                    weight_valid,
    input  logic                    weight_ready
);

    localparam int c_beat_w = WEIGHT_WIDTH * WEIGHT_SIZE;
    // Wide enough for num_passes * NUM_BEATS without overflow.
    localparam int c_cnt_w  = PASS_WIDTH + ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   c_num_beats_ext = (ADDR_WIDTH + 1)'(NUM_BEATS);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr     = ADDR_WIDTH'(NUM_BEATS - 1);
    localparam logic [c_cnt_w-1:0]    c_num_beats_cnt = c_cnt_w'(NUM_BEATS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    logic [c_beat_w-1:0]   r_mem [NUM_BEATS];
    logic [c_beat_w-1:0]   r_rd_data;
    logic                  r_rd_valid;
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [c_cnt_w-1:0]    r_iss_left;
    logic [c_cnt_w-1:0]    r_xfer_left;
    logic                  r_done;
    logic [c_beat_w-1:0]   r_buf [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_count;

    logic [c_beat_w-1:0]   w_wr_beat;
    logic [c_beat_w-1:0]   w_head;
    logic                  w_wr_ok;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_last_xfer;
    logic [c_cnt_w-1:0]    w_start_total;

    // Flatten the incoming beat into one memory word.
    always_comb begin
        w_wr_beat = '0;
        for (int i = 0; i < WEIGHT_SIZE; i++) begin
            w_wr_beat[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wr_data[i];
        end
    end

    // Writes are only honoured while idle and for in-range addresses.
    assign w_wr_ok = wr_en && (r_state == IDLE) && ({1'b0, wr_addr} < c_num_beats_ext);

    // A read is issued only when the buffer plus the read stage cannot overflow.
    // The decision uses registered occupancy only, so the consumer's ready
    // never feeds the read address path.
    assign w_issue = (r_state == STREAM) && (r_iss_left != '0)
                   && (({1'b0, r_count} + {2'b00, r_rd_valid}) < 3'd3);

    assign w_pop         = (r_count != 2'd0) && weight_ready;
    assign w_push        = r_rd_valid && ((r_count != 2'd2) || w_pop);
    assign w_last_xfer   = w_pop && (r_xfer_left == c_cnt_w'(1));
    assign w_start_total = c_cnt_w'(num_passes) * c_num_beats_cnt;

    // Weight storage: synchronous write, registered read; never reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[wr_addr] <= w_wr_beat;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[r_rd_addr];
        end
    end

    // Command FSM: read sequencing, transfer counting and done generation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rd_addr   <= '0;
            r_iss_left  <= '0;
            r_xfer_left <= '0;
            r_done      <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (num_passes != '0) begin
                            r_state     <= STREAM;
                            r_rd_addr   <= '0;
                            r_iss_left  <= w_start_total;
                            r_xfer_left <= w_start_total;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (w_issue) begin
                        r_iss_left <= r_iss_left - c_cnt_w'(1);
                        r_rd_addr  <= (r_rd_addr == c_last_addr) ? '0
                                                                 : r_rd_addr + ADDR_WIDTH'(1);
                    end
                    if (w_pop) begin
                        r_xfer_left <= r_xfer_left - c_cnt_w'(1);
                    end
                    if (w_last_xfer) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // A new read lands in the read stage; otherwise it empties when moved on.
            if (w_issue) begin
                r_rd_valid <= 1'b1;
            end else if (w_push) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // Two-entry output buffer fed from the read stage, drained by the consumer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wptr] <= r_rd_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head       = r_buf[r_rptr];
    assign busy         = (r_state == STREAM);
    assign done         = r_done;
    assign weight_valid = (r_count != 2'd0);

    // Unpack the buffer head into per-element output lanes.
    always_comb begin
        for (int i = 0; i < WEIGHT_SIZE; i++) begin
            weight[i] = w_head[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    end

endmodule
`default_nettype wire
